// File: rtl/serial_pkg.sv
// Shared types and constants for the serial link (deserializer and serializer side).
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CLK_DIV_DEFAULT = 100;
  localparam int WORD_W_DEFAULT  = 8;
  localparam int MEM_DEPTH       = 62500;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/serial_deserializer.sv
// Start/stop framed serial receiver: mid-bit sampling, LSB-first data, one-cycle
// done / frame_err pulses.
import serial_pkg::*;

module serial_deserializer #(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int WORD_W  = WORD_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              serial_in,
  output logic [WORD_W-1:0] data_out,
  output logic              done,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(WORD_W + 1);
  localparam int HALF = CLK_DIV / 2;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [WORD_W-1:0] shreg;
  logic              rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      if (!enable) begin
        // Dropping enable abandons any partial word without reporting it.
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
        shreg   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == CNT_HALF) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == CNT_FULL) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[WORD_W-1:1]};
              if (bit_idx == LAST_BIT) begin
                bit_idx <= '0;
                state   <= STOP;
              end else begin
                bit_idx <= bit_idx + BW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == CNT_FULL) begin
              cnt   <= '0;
              state <= IDLE;
              if (rx_s) begin
                data_out <= shreg;
                done     <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: framing, latency, glitch reject,
// frame error, mid-frame reset and enable drop.
module tb_serial_deserializer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       done, frame_err, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int done_cnt = 0, fe_cnt = 0, viol = 0, brun = 0, bmax = 0;
  int done_t[$];
  logic [7:0] done_d[$];
  logic prev_pulse = 1'b0;
  int frame_start = 0;

  serial_deserializer #(.CLK_DIV(100), .WORD_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .serial_in (serial_in),
    .data_out  (data_out),
    .done      (done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Observe pulses away from the active edge.
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      done_t.push_back(cyc);
      done_d.push_back(data_out);
    end
    if (frame_err) fe_cnt++;
    if ((done && frame_err) || ((done || frame_err) && prev_pulse)) viol++;
    prev_pulse = done | frame_err;
    if (busy) begin
      brun++;
      if (brun > bmax) bmax = brun;
    end else begin
      brun = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // mode 1: pulse reset at mid of abort_bit; mode 2: drop enable for one cycle.
  task automatic send(input logic [7:0] d, input logic stop_b,
                      input int abort_bit, input int mode);
    serial_in   = 1'b0;
    frame_start = cyc + 1;
    repeat (100) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      if (i == abort_bit) begin
        repeat (50) tick();
        if (mode == 1) begin
          reset = 1'b1;
          tick();
          chk("rst_mid_data", data_out, 0);
          chk("rst_mid_done", done, 0);
          chk("rst_mid_ferr", frame_err, 0);
          chk("rst_mid_busy", busy, 0);
          reset = 1'b0;
        end else begin
          enable = 1'b0;
          tick();
          chk("en_drop_busy", busy, 0);
          enable = 1'b1;
        end
        serial_in = 1'b1;
        repeat (149) tick();
        return;
      end
      repeat (100) tick();
    end
    serial_in = stop_b;
    repeat (100) tick();
    serial_in = 1'b1;
  endtask

  initial begin
    int d0, f0;
    repeat (3) tick();
    chk("reset_data", data_out, 0);
    chk("reset_done", done, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    repeat (20) tick();

    // Single 0xA5 frame
    send(8'hA5, 1'b1, -1, 0);
    repeat (20) tick();
    chk("a5_done_cnt", done_cnt, 1);
    chk("a5_ferr_cnt", fe_cnt, 0);
    chk("a5_data", data_out, 8'hA5);
    if (done_t.size() >= 1)
      chk_rng("a5_latency", done_t[0] - frame_start, 951, 953);
    else
      chk("a5_latency_seen", done_t.size(), 1);

    // Back-to-back 0x00 then 0xFF
    send(8'h00, 1'b1, -1, 0);
    send(8'hFF, 1'b1, -1, 0);
    repeat (20) tick();
    chk("b2b_done_cnt", done_cnt, 3);
    if (done_t.size() >= 3) begin
      chk("b2b_first_data", done_d[1], 8'h00);
      chk("b2b_second_data", done_d[2], 8'hFF);
      chk_rng("b2b_gap", done_t[2] - done_t[1], 999, 1001);
    end else begin
      chk("b2b_pulses_seen", done_t.size(), 3);
    end

    // 30-cycle glitch on idle line
    bmax = 0;
    d0 = done_cnt; f0 = fe_cnt;
    serial_in = 1'b0;
    repeat (30) tick();
    serial_in = 1'b1;
    repeat (200) tick();
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_ferr", fe_cnt - f0, 0);
    chk_rng("glitch_busy_len", bmax, 1, 52);
    chk("glitch_idle", busy, 0);

    // 0x3C with bad stop bit
    d0 = done_cnt; f0 = fe_cnt;
    send(8'h3C, 1'b0, -1, 0);
    repeat (200) tick();
    chk("ferr_pulses", fe_cnt - f0, 1);
    chk("ferr_no_done", done_cnt - d0, 0);
    chk("ferr_data_kept", data_out, 8'hFF);

    // Reset at bit 4 of 0x5A, then clean 0x5A
    send(8'h5A, 1'b1, 4, 1);
    repeat (200) tick();
    d0 = done_cnt;
    send(8'h5A, 1'b1, -1, 0);
    repeat (20) tick();
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_data", data_out, 8'h5A);

    // Enable dropped for one cycle mid 0xF0, then clean 0x96
    d0 = done_cnt; f0 = fe_cnt;
    send(8'hF0, 1'b1, 5, 2);
    repeat (1200) tick();
    chk("en_drop_no_done", done_cnt - d0, 0);
    chk("en_drop_no_ferr", fe_cnt - f0, 0);
    chk("en_drop_data_kept", data_out, 8'h5A);
    send(8'h96, 1'b1, -1, 0);
    repeat (20) tick();
    chk("after_drop_done", done_cnt - d0, 1);
    chk("after_drop_data", data_out, 8'h96);

    chk("pulse_exclusive", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter CLK_DIV, default 100: clock cycles per serial bit (100 MHz clock, 1 Mbit/s line).
REQ-002 Parameter WORD_W, default 8: data bits per frame.
REQ-003 Port clock, input, 1: 100 MHz system clock; all logic on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: receiver enable; low forces idle.
REQ-006 Port serial_in, input, 1: asynchronous serial line, idle high.
REQ-007 Port data_out, output, WORD_W: last correctly framed word, held until the next good frame.
REQ-008 Port done, output, 1: one-cycle pulse per good frame; drives the downstream address counter's advance input.
REQ-009 Port frame_err, output, 1: one-cycle pulse when the stop bit samples low.
REQ-010 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-011 The block SHALL pass serial_in through a 2-flop synchronizer; only the second flop (rx_s) feeds the logic.
REQ-012 Frame format SHALL be: start bit (0), WORD_W data bits LSB first, stop bit (1); no parity.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 In IDLE with enable=1 and rx_s=0, the FSM SHALL go to START and clear the bit-timing counter.
REQ-015 In START, at counter = CLK_DIV/2-1, the block SHALL go to DATA and clear the counter if rx_s=0; otherwise it SHALL return to IDLE (glitch reject).
REQ-016 In DATA, at counter = CLK_DIV-1, the block SHALL shift rx_s into the MSB of the shift register (right shift) and increment the bit index; after WORD_W samples it SHALL go to STOP.
REQ-017 In STOP, at counter = CLK_DIV-1, with rx_s=1 the block SHALL load data_out from the shift register and pulse done for exactly one cycle in the same cycle; with rx_s=0 it SHALL pulse frame_err for one cycle and leave data_out unchanged. In both cases it SHALL go to IDLE.
REQ-018 The bit-timing counter SHALL be $clog2(CLK_DIV) bits wide and SHALL wrap to 0 on each sample point.
REQ-019 done and frame_err SHALL never be high together, and SHALL never be high on consecutive cycles.
REQ-020 enable=0 in any state SHALL force IDLE on the next edge, discard the partial word, and suppress done and frame_err.
REQ-021 A low line that is still low on re-entry to IDLE (a break condition) SHALL start a new frame immediately.
REQ-022 Latency from the first clock edge that samples serial_in low to the done pulse SHALL be 2 + CLK_DIV/2 + (WORD_W+1)*CLK_DIV cycles, ±1.

Reset
REQ-023 reset SHALL set state=IDLE, counter=0, bit index=0, shift register=0, data_out=0, done=0, frame_err=0, and busy=0.
REQ-024 reset SHALL set both synchronizer flops to 1 (idle line).
REQ-025 reset SHALL take priority over enable and over every FSM transition, including mid-frame.

Structure
REQ-026 Package serial_pkg SHALL hold the state enum type, CLK_DIV_DEFAULT=100, WORD_W_DEFAULT=8, and MEM_DEPTH=62500; the serializer side shares this package.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff, instantiated once; the FSM, counter, and shift register stay in serial_deserializer.

Verification
REQ-028 Frame 0xA5 at 100 cycles/bit with enable=1 -> exactly one done pulse, 952±1 cycles after the start edge; data_out=0xA5; frame_err stays 0.
REQ-029 Frames 0x00 then 0xFF back-to-back -> two done pulses 1000±1 cycles apart; data_out=0x00, then 0xFF.
REQ-030 30-cycle low glitch on an idle line -> return to IDLE; no done; no frame_err; busy high for no more than 52 cycles.
REQ-031 Frame 0x3C with stop bit driven 0 -> one frame_err pulse; no done; data_out keeps its previous value.
REQ-032 reset asserted at bit 4 of frame 0x5A -> all outputs 0 on the next edge; a following clean 0x5A frame -> done with data_out=0x5A.
REQ-033 enable dropped mid-frame for 1 cycle -> no done for that frame; the next full frame is received correctly.
